// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM: steps the shared datapath through
// IF/ID/EX/MEM/WB, waits on the data-memory ready handshake, and halts
// with a sticky error on an illegal instruction or a memory timeout.
module multi_cycle_ctrl #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op_code,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PC_Write,
    output logic [1:0] PC_src,
    output logic       IR_Write,
    output logic       Write_Reg,
    output logic [2:0] ALU_OP,
    output logic       rd_rt_s,
    output logic       imm_s,
    output logic       rt_imm_s,
    output logic       alu_mem_s,
    output logic       Mem_Read,
    output logic       Mem_Write,
    output logic       halt,
    output logic       err
);

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_RALU, C_IALU, C_LW, C_SW, C_BEQ, C_J
    } cls_t;

    state_t     state, state_nxt;
    logic [5:0] op_q, funct_q;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       err_nxt;

    cls_t       cls;
    logic [2:0] d_aop;
    logic       d_rdrt, d_imm, d_rtimm, d_am;

    // Instruction legality check on the live IR fields during ID
    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_R: begin
                case (fn)
                    6'b100000, 6'b100010, 6'b100100, 6'b100101,
                    6'b100110, 6'b100111, 6'b101011, 6'b000100: ok = 1'b1;
                    default: ok = 1'b0;
                endcase
            end
            OP_ADDI, OP_ANDI, OP_XORI, OP_SLTIU,
            OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // State, latched instruction fields, wait counter and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            op_q     <= '0;
            funct_q  <= '0;
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            err      <= err_nxt;
            if (state == S_ID) begin
                op_q    <= op_code;
                funct_q <= funct;
            end
        end
    end

    // Decode latched op/funct into instruction class and datapath fields
    always_comb begin
        cls      = C_J;
        d_aop    = 3'b000;
        d_rdrt   = 1'b0;
        d_imm    = 1'b0;
        d_rtimm  = 1'b0;
        d_am     = 1'b0;
        case (op_q)
            OP_R: begin
                cls = C_RALU;
                case (funct_q)
                    6'b100000: d_aop = 3'b100;
                    6'b100010: d_aop = 3'b101;
                    6'b100100: d_aop = 3'b000;
                    6'b100101: d_aop = 3'b001;
                    6'b100110: d_aop = 3'b010;
                    6'b100111: d_aop = 3'b011;
                    6'b101011: d_aop = 3'b110;
                    6'b000100: d_aop = 3'b111;
                    default:   d_aop = 3'b000;
                endcase
            end
            OP_ADDI:  begin cls = C_IALU; d_aop = 3'b100; d_imm = 1'b1; d_rtimm = 1'b1; d_rdrt = 1'b1; end
            OP_ANDI:  begin cls = C_IALU; d_aop = 3'b000; d_rtimm = 1'b1; d_rdrt = 1'b1; end
            OP_XORI:  begin cls = C_IALU; d_aop = 3'b010; d_rtimm = 1'b1; d_rdrt = 1'b1; end
            OP_SLTIU: begin cls = C_IALU; d_aop = 3'b110; d_rtimm = 1'b1; d_rdrt = 1'b1; end
            OP_LW:    begin cls = C_LW; d_aop = 3'b100; d_imm = 1'b1; d_rtimm = 1'b1; d_rdrt = 1'b1; d_am = 1'b1; end
            OP_SW:    begin cls = C_SW; d_aop = 3'b100; d_imm = 1'b1; d_rtimm = 1'b1; end
            OP_BEQ:   begin cls = C_BEQ; d_aop = 3'b101; end
            default:  cls = C_J;
        endcase
    end

    // Next-state and per-state control outputs
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        err_nxt      = err;
        PC_Write     = 1'b0;
        PC_src       = 2'b00;
        IR_Write     = 1'b0;
        Write_Reg    = 1'b0;
        ALU_OP       = 3'b000;
        rd_rt_s      = 1'b0;
        imm_s        = 1'b0;
        rt_imm_s     = 1'b0;
        alu_mem_s    = 1'b0;
        Mem_Read     = 1'b0;
        Mem_Write    = 1'b0;
        halt         = 1'b0;

        // Datapath selects stay stable for the whole EX..WB span
        if (state == S_EX || state == S_MEM || state == S_WB) begin
            ALU_OP    = d_aop;
            rd_rt_s   = d_rdrt;
            imm_s     = d_imm;
            rt_imm_s  = d_rtimm;
            alu_mem_s = d_am;
        end

        case (state)
            S_IDLE: state_nxt = S_IF;
            S_IF: begin
                IR_Write  = 1'b1;
                PC_Write  = 1'b1;
                state_nxt = S_ID;
            end
            S_ID: begin
                if (is_legal(op_code, funct)) begin
                    state_nxt = S_EX;
                end else begin
                    state_nxt = S_HALT;
                    err_nxt   = 1'b1;
                end
            end
            S_EX: begin
                wait_cnt_nxt = '0;
                case (cls)
                    C_RALU, C_IALU: state_nxt = S_WB;
                    C_LW, C_SW:     state_nxt = S_MEM;
                    C_BEQ: begin
                        PC_src    = 2'b01;
                        PC_Write  = zero;
                        state_nxt = S_IF;
                    end
                    default: begin
                        PC_src    = 2'b10;
                        PC_Write  = 1'b1;
                        state_nxt = S_IF;
                    end
                endcase
            end
            S_MEM: begin
                Mem_Read  = (cls == C_LW);
                Mem_Write = (cls == C_SW);
                // ready is checked before the timeout so a late ready still succeeds
                if (mem_ready) begin
                    wait_cnt_nxt = '0;
                    state_nxt    = (cls == C_LW) ? S_WB : S_IF;
                end else if (wait_cnt == WAIT_LAST) begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                    state_nxt    = S_HALT;
                    err_nxt      = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            S_WB: begin
                Write_Reg = 1'b1;
                state_nxt = S_IF;
            end
            S_HALT: halt = 1'b1;
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed, table-driven bench for multi_cycle_ctrl: one cycle per vector,
// outputs compared as a packed word against hand-computed values.
module tb_multi_cycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op_code = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PC_Write, IR_Write, Write_Reg, rd_rt_s, imm_s, rt_imm_s;
    logic       alu_mem_s, Mem_Read, Mem_Write, halt, err;
    logic [1:0] PC_src;
    logic [2:0] ALU_OP;

    int checks = 0;
    int errors = 0;

    multi_cycle_ctrl #(.WAIT_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n), .op_code(op_code), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .PC_Write(PC_Write),
        .PC_src(PC_src), .IR_Write(IR_Write), .Write_Reg(Write_Reg),
        .ALU_OP(ALU_OP), .rd_rt_s(rd_rt_s), .imm_s(imm_s),
        .rt_imm_s(rt_imm_s), .alu_mem_s(alu_mem_s), .Mem_Read(Mem_Read),
        .Mem_Write(Mem_Write), .halt(halt), .err(err)
    );

    always #5 clk = ~clk;

    // [15]PC_Write [14:13]PC_src [12]IR_Write [11]Write_Reg [10:8]ALU_OP
    // [7]rd_rt_s [6]imm_s [5]rt_imm_s [4]alu_mem_s [3]Mem_Read [2]Mem_Write [1]halt [0]err
    logic [15:0] act;
    assign act = {PC_Write, PC_src, IR_Write, Write_Reg, ALU_OP, rd_rt_s, imm_s,
                  rt_imm_s, alu_mem_s, Mem_Read, Mem_Write, halt, err};

    function automatic logic [15:0] ev(input logic pcw, input logic [1:0] pcs,
                                       input logic irw, input logic wr,
                                       input logic [2:0] aop, input logic rdrt,
                                       input logic imm, input logic rtimm,
                                       input logic am, input logic mr,
                                       input logic mw, input logic h, input logic e);
        return {pcw, pcs, irw, wr, aop, rdrt, imm, rtimm, am, mr, mw, h, e};
    endfunction

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string nm, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy, input logic [15:0] exp);
        vec_t v;
        v.name = nm; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.exp = exp;
        tbl.push_back(v);
    endtask

    task automatic check(input string nm, input logic [15:0] a, input logic [15:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, a, e);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and check the outputs 1ns later
    task automatic apply(input string nm, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input logic rdy, input logic [15:0] exp);
        @(negedge clk);
        op_code = op; funct = fn; zero = z; mem_ready = rdy;
        #1;
        check(nm, act, exp);
    endtask

    // Leaves the DUT in IDLE with no rising edge yet seen after release
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("reset", act, 16'h0000);
        rst_n = 1'b1;
    endtask

    logic [15:0] e_if, e_halt, e_sw_ex, e_sw_mem, e_lw_ex, e_lw_mem, e_lw_wb;

    initial begin
        e_if     = ev(1, 2'b00, 1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
        e_halt   = ev(0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 1);
        e_sw_ex  = ev(0, 2'b00, 0, 0, 3'b100, 0, 1, 1, 0, 0, 0, 0, 0);
        e_sw_mem = ev(0, 2'b00, 0, 0, 3'b100, 0, 1, 1, 0, 0, 1, 0, 0);
        e_lw_ex  = ev(0, 2'b00, 0, 0, 3'b100, 1, 1, 1, 1, 0, 0, 0, 0);
        e_lw_mem = ev(0, 2'b00, 0, 0, 3'b100, 1, 1, 1, 1, 1, 0, 0, 0);
        e_lw_wb  = ev(0, 2'b00, 0, 1, 3'b100, 1, 1, 1, 1, 0, 0, 0, 0);

        // add: IDLE, IF, ID, EX, WB (zero/mem_ready toggled where they must be ignored)
        add("add_idle", 6'h00, 6'h20, 1, 1, 16'h0000);
        add("add_if",   6'h00, 6'h20, 1, 1, e_if);
        add("add_id",   6'h00, 6'h20, 1, 1, 16'h0000);
        add("add_ex",   6'h00, 6'h20, 1, 1, ev(0, 2'b00, 0, 0, 3'b100, 0, 0, 0, 0, 0, 0, 0, 0));
        add("add_wb",   6'h00, 6'h20, 1, 1, ev(0, 2'b00, 0, 1, 3'b100, 0, 0, 0, 0, 0, 0, 0, 0));
        // lw with three wait cycles: eight cycles IF..WB
        add("lw_if",    6'h23, 6'h00, 0, 0, e_if);
        add("lw_id",    6'h23, 6'h00, 0, 1, 16'h0000);
        add("lw_ex",    6'h23, 6'h00, 0, 1, e_lw_ex);
        add("lw_m0",    6'h23, 6'h00, 0, 0, e_lw_mem);
        add("lw_m1",    6'h23, 6'h00, 0, 0, e_lw_mem);
        add("lw_m2",    6'h23, 6'h00, 0, 0, e_lw_mem);
        add("lw_m3",    6'h23, 6'h00, 0, 1, e_lw_mem);
        add("lw_wb",    6'h23, 6'h00, 0, 0, e_lw_wb);
        // beq taken, then not taken
        add("beq1_if",  6'h04, 6'h00, 1, 0, e_if);
        add("beq1_id",  6'h04, 6'h00, 0, 0, 16'h0000);
        add("beq1_ex",  6'h04, 6'h00, 1, 0, ev(1, 2'b01, 0, 0, 3'b101, 0, 0, 0, 0, 0, 0, 0, 0));
        add("beq0_if",  6'h04, 6'h00, 1, 0, e_if);
        add("beq0_id",  6'h04, 6'h00, 1, 0, 16'h0000);
        add("beq0_ex",  6'h04, 6'h00, 0, 0, ev(0, 2'b01, 0, 0, 3'b101, 0, 0, 0, 0, 0, 0, 0, 0));
        // j
        add("j_if",     6'h02, 6'h00, 0, 0, e_if);
        add("j_id",     6'h02, 6'h00, 0, 0, 16'h0000);
        add("j_ex",     6'h02, 6'h00, 0, 0, ev(1, 2'b10, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0));
        // andi: zero-extended immediate, dest rt
        add("andi_if",  6'h0C, 6'h00, 0, 0, e_if);
        add("andi_id",  6'h0C, 6'h00, 0, 0, 16'h0000);
        add("andi_ex",  6'h0C, 6'h00, 0, 0, ev(0, 2'b00, 0, 0, 3'b000, 1, 0, 1, 0, 0, 0, 0, 0));
        add("andi_wb",  6'h0C, 6'h00, 0, 0, ev(0, 2'b00, 0, 1, 3'b000, 1, 0, 1, 0, 0, 0, 0, 0));
        // addi: sign-extended immediate
        add("addi_if",  6'h08, 6'h00, 0, 0, e_if);
        add("addi_id",  6'h08, 6'h00, 0, 0, 16'h0000);
        add("addi_ex",  6'h08, 6'h00, 0, 0, ev(0, 2'b00, 0, 0, 3'b100, 1, 1, 1, 0, 0, 0, 0, 0));
        add("addi_wb",  6'h08, 6'h00, 0, 0, ev(0, 2'b00, 0, 1, 3'b100, 1, 1, 1, 0, 0, 0, 0, 0));
        // sltu and sllv R-type
        add("sltu_if",  6'h00, 6'h2B, 0, 0, e_if);
        add("sltu_id",  6'h00, 6'h2B, 0, 0, 16'h0000);
        add("sltu_ex",  6'h00, 6'h2B, 0, 0, ev(0, 2'b00, 0, 0, 3'b110, 0, 0, 0, 0, 0, 0, 0, 0));
        add("sltu_wb",  6'h00, 6'h2B, 0, 0, ev(0, 2'b00, 0, 1, 3'b110, 0, 0, 0, 0, 0, 0, 0, 0));
        add("sllv_if",  6'h00, 6'h04, 0, 0, e_if);
        add("sllv_id",  6'h00, 6'h04, 0, 0, 16'h0000);
        add("sllv_ex",  6'h00, 6'h04, 0, 0, ev(0, 2'b00, 0, 0, 3'b111, 0, 0, 0, 0, 0, 0, 0, 0));
        add("sllv_wb",  6'h00, 6'h04, 0, 0, ev(0, 2'b00, 0, 1, 3'b111, 0, 0, 0, 0, 0, 0, 0, 0));
        add("end_if",   6'h00, 6'h00, 0, 0, e_if);

        do_reset();
        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i].name, tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].rdy, tbl[i].exp);

        // sw with mem_ready never high: 15 MEM cycles then HALT until reset
        do_reset();
        apply("to_idle", 6'h2B, 6'h00, 0, 0, 16'h0000);
        apply("to_if",   6'h2B, 6'h00, 0, 0, e_if);
        apply("to_id",   6'h2B, 6'h00, 0, 0, 16'h0000);
        apply("to_ex",   6'h2B, 6'h00, 0, 0, e_sw_ex);
        for (int i = 0; i < 15; i++)
            apply($sformatf("to_mem%0d", i), 6'h2B, 6'h00, 0, 0, e_sw_mem);
        for (int i = 0; i < 4; i++)
            apply($sformatf("to_halt%0d", i), 6'h2B, 6'h00, 1, 1, e_halt);

        // sw with ready arriving on the 15th MEM cycle: success, back to IF
        do_reset();
        apply("edge_idle", 6'h2B, 6'h00, 0, 0, 16'h0000);
        apply("edge_if",   6'h2B, 6'h00, 0, 0, e_if);
        apply("edge_id",   6'h2B, 6'h00, 0, 0, 16'h0000);
        apply("edge_ex",   6'h2B, 6'h00, 0, 0, e_sw_ex);
        for (int i = 0; i < 14; i++)
            apply($sformatf("edge_mem%0d", i), 6'h2B, 6'h00, 0, 0, e_sw_mem);
        apply("edge_mem14", 6'h2B, 6'h00, 0, 1, e_sw_mem);
        apply("edge_if2",   6'h2B, 6'h00, 0, 0, e_if);

        // Illegal opcode 111111 halts directly after ID
        do_reset();
        apply("ill_idle", 6'h3F, 6'h00, 0, 0, 16'h0000);
        apply("ill_if",   6'h3F, 6'h00, 0, 0, e_if);
        apply("ill_id",   6'h3F, 6'h00, 0, 0, 16'h0000);
        for (int i = 0; i < 3; i++)
            apply($sformatf("ill_halt%0d", i), 6'h00, 6'h20, 1, 1, e_halt);

        // Illegal R-type funct (addu) also halts
        do_reset();
        apply("illf_idle", 6'h00, 6'h21, 0, 0, 16'h0000);
        apply("illf_if",   6'h00, 6'h21, 0, 0, e_if);
        apply("illf_id",   6'h00, 6'h21, 0, 0, 16'h0000);
        apply("illf_halt", 6'h00, 6'h21, 0, 0, e_halt);

        // Reset asserted mid-MEM of a sw drops Mem_Write immediately
        do_reset();
        apply("rm_idle", 6'h2B, 6'h00, 0, 0, 16'h0000);
        apply("rm_if",   6'h2B, 6'h00, 0, 0, e_if);
        apply("rm_id",   6'h2B, 6'h00, 0, 0, 16'h0000);
        apply("rm_ex",   6'h2B, 6'h00, 0, 0, e_sw_ex);
        apply("rm_mem0", 6'h2B, 6'h00, 0, 0, e_sw_mem);
        apply("rm_mem1", 6'h2B, 6'h00, 0, 0, e_sw_mem);
        #2 rst_n = 1'b0;
        #1 check("rm_async", act, 16'h0000);
        @(posedge clk);
        #2 rst_n = 1'b1;
        apply("rm_idle2", 6'h23, 6'h00, 0, 0, 16'h0000);
        apply("rm_if2",   6'h23, 6'h00, 0, 0, e_if);
        apply("rm_id2",   6'h23, 6'h00, 0, 0, 16'h0000);
        apply("rm_ex2",   6'h23, 6'h00, 0, 0, e_lw_ex);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
